toggle_data_rx: RTL and testbench

TOGGLE_DATA_RX -- requirements
Module: toggle_data_rx

---
 rtl/toggle_data_rx_if.sv | 31 +++
 rtl/toggle_data_rx.sv | 121 ++++++++++++
 tb/tb_toggle_data_rx.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/toggle_data_rx_if.sv
// toggle_data_rx_if: bundles the toggle-qualified read-data input, the
// show-ahead consumer handshake and the status/clear signals of
// toggle_data_rx.
//   master : source/consumer side (drives data_toggle, rd_data, rready, clr_overflow)
//   slave  : receiver side (drives rvalid, rdata, level, overflow, rx_count)
interface toggle_data_rx_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic              data_toggle;
  logic [DATA_W-1:0] rd_data;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              rready;
  logic [LW-1:0]     level;
  logic              overflow;
  logic              clr_overflow;
  logic [15:0]       rx_count;

  modport master (
    output data_toggle, rd_data, rready, clr_overflow,
    input  rvalid, rdata, level, overflow, rx_count
  );

  modport slave (
    input  data_toggle, rd_data, rready, clr_overflow,
    output rvalid, rdata, level, overflow, rx_count
  );
endinterface

// File: rtl/toggle_data_rx.sv
// toggle_data_rx: captures one rd_data word per level change of data_toggle
// into a small show-ahead buffer drained with an rvalid/rready handshake.
// Tracks occupancy, a sticky overflow flag for dropped words and a
// wrapping 16-bit count of accepted words.
// Ports:
//   Clk  - system clock, rising edge
//   Rst  - asynchronous active-low reset
//   bus  - toggle_data_rx_if.slave (data_toggle, rd_data, rready,
//          clr_overflow in; rvalid, rdata, level, overflow, rx_count out)
// Build option: define TOGGLE_RX_SYNC_EN to pass data_toggle through a
// two-flop synchroniser (toggle-to-rvalid latency 3 cycles instead of 1).
//
// Occupancy FSM:
//   state      | meaning
//   ST_EMPTY   | level == 0, rvalid low, rdata forced to zero
//   ST_PARTIAL | 0 < level < DEPTH
//   ST_FULL    | level == DEPTH, a push without a same-cycle pop is dropped
module toggle_data_rx #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input logic             Clk,
  input logic             Rst,
  toggle_data_rx_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_LAST = LW'(DEPTH - 1);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);

  typedef enum logic [1:0] {ST_EMPTY, ST_PARTIAL, ST_FULL} occ_t;

  occ_t              occ_st;
  logic              toggle_s;
  logic              tog_q;
  logic              tog_edge;
  logic              push;
  logic              pop;
  logic              full;
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [LW-1:0]     level_q;
  logic              overflow_q;
  logic [15:0]       rx_count_q;
  logic [DATA_W-1:0] mem [DEPTH];

`ifdef TOGGLE_RX_SYNC_EN
  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= bus.data_toggle;
      sync2_q <= sync1_q;
    end
  end

  assign toggle_s = sync2_q;
`else
  assign toggle_s = bus.data_toggle;
`endif

  assign tog_edge = toggle_s ^ tog_q;
  assign full     = (occ_st == ST_FULL);
  assign pop      = (occ_st != ST_EMPTY) && bus.rready;
  // A full buffer still takes the new word when the head leaves this cycle.
  assign push     = tog_edge && (!full || pop);

  always_ff @(posedge Clk) begin
    if (push) mem[wptr] <= bus.rd_data;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      tog_q      <= 1'b0;
      wptr       <= '0;
      rptr       <= '0;
      level_q    <= '0;
      occ_st     <= ST_EMPTY;
      overflow_q <= 1'b0;
      rx_count_q <= '0;
    end else begin
      tog_q <= toggle_s;
      if (push) begin
        wptr       <= wptr + AW'(1);
        rx_count_q <= rx_count_q + 16'd1;
      end
      if (pop) rptr <= rptr + AW'(1);

      if (push && !pop)      level_q <= level_q + LVL_ONE;
      else if (pop && !push) level_q <= level_q - LVL_ONE;

      // Set wins over a simultaneous clear.
      if (tog_edge && !push)      overflow_q <= 1'b1;
      else if (bus.clr_overflow)  overflow_q <= 1'b0;

      case (occ_st)
        ST_EMPTY:   if (push) occ_st <= ST_PARTIAL;
        ST_PARTIAL: begin
          if (push && !pop && level_q == LVL_LAST)     occ_st <= ST_FULL;
          else if (pop && !push && level_q == LVL_ONE) occ_st <= ST_EMPTY;
        end
        ST_FULL:    if (pop && !push) occ_st <= ST_PARTIAL;
        default:    occ_st <= ST_EMPTY;
      endcase
    end
  end

  assign bus.rvalid   = (occ_st != ST_EMPTY);
  assign bus.rdata    = bus.rvalid ? mem[rptr] : '0;
  assign bus.level    = level_q;
  assign bus.overflow = overflow_q;
  assign bus.rx_count = rx_count_q;

  logic unused_full_lvl;
  assign unused_full_lvl = ^LVL_FULL;
endmodule

// File: tb/tb_toggle_data_rx.sv
module tb_toggle_data_rx;
`ifdef TOGGLE_RX_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic Clk;
  logic Rst;
  int   tests;
  int   fails;
  logic [31:0] expq [$];

  toggle_data_rx_if #(.DATA_W(32), .DEPTH(4)) bus ();

  toggle_data_rx #(.DATA_W(32), .DEPTH(4)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // Present a word and flip the toggle, then wait until it has been captured.
  task automatic send(input logic [31:0] d, input bit acc);
    bus.rd_data     = d;
    bus.data_toggle = ~bus.data_toggle;
    if (acc) expq.push_back(d);
    tick(LAT + 1);
  endtask

  // Scoreboard monitor: every handshake must deliver the next expected word.
  always @(negedge Clk) begin
    if (Rst && bus.rvalid && bus.rready) begin
      tests++;
      if (expq.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: got word 0x%0h, required no word", bus.rdata);
      end else begin
        logic [31:0] w;
        w = expq.pop_front();
        if (bus.rdata !== w) begin
          fails++;
          $display("FAIL sb_data: got 0x%0h, required 0x%0h", bus.rdata, w);
        end
      end
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    Rst = 1'b0;
    bus.data_toggle  = 1'b0;
    bus.rd_data      = '0;
    bus.rready       = 1'b0;
    bus.clr_overflow = 1'b0;

    // Reset state
    tick(2);
    chk("rst_rvalid",   bus.rvalid,   0);
    chk("rst_rdata",    bus.rdata,    0);
    chk("rst_level",    bus.level,    0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_rx_count", bus.rx_count, 0);
    Rst = 1'b1;
    tick(2);
    chk("no_spurious_push", bus.level, 0);

    // Basic word path
    bus.rready      = 1'b1;
    bus.rd_data     = 32'hA5A5_0001;
    bus.data_toggle = 1'b1;
    expq.push_back(32'hA5A5_0001);
    tick(LAT - 1);
    chk("basic_early_rvalid", bus.rvalid, 0);
    tick(1);
    chk("basic_rvalid", bus.rvalid, 1);
    chk("basic_rdata",  bus.rdata,  64'hA5A5_0001);
    tick(1);
    chk("basic_rvalid_after", bus.rvalid, 0);
    chk("basic_rx_count",     bus.rx_count, 1);

    // Backpressure, fill to FULL, overflow drop, drain order
    bus.rready = 1'b0;
    for (int i = 0; i < 4; i++) send(32'h10 + 32'(i), 1'b1);
    chk("bp_level",    bus.level,    4);
    chk("bp_rdata",    bus.rdata,    64'h10);
    chk("bp_rvalid",   bus.rvalid,   1);
    chk("bp_no_ovf",   bus.overflow, 0);
    send(32'h14, 1'b0);
    chk("ovf_set",      bus.overflow, 1);
    chk("ovf_level",    bus.level,    4);
    chk("ovf_rx_count", bus.rx_count, 5);  // 1 from the basic word + 4
    chk("ovf_head",     bus.rdata,    64'h10);
    bus.rready = 1'b1;
    tick(4);
    chk("drain_level", bus.level, 0);

    // Push and pop in the same cycle while FULL
    bus.rready = 1'b0;
    for (int i = 0; i < 4; i++) send(32'h30 + 32'(i), 1'b1);
    chk("pp_full_level", bus.level, 4);
    bus.rd_data     = 32'h20;
    bus.data_toggle = ~bus.data_toggle;
    expq.push_back(32'h20);
    tick(LAT - 1);
    bus.rready = 1'b1;
    tick(1);
    bus.rready = 1'b0;
    chk("pp_level", bus.level, 4);
    chk("pp_rdata", bus.rdata, 64'h31);
    bus.rready = 1'b1;
    tick(4);
    chk("pp_drain_level", bus.level, 0);
    chk("pp_ovf_sticky",  bus.overflow, 1);

    // Overflow set/clear priority
    bus.rready       = 1'b0;
    bus.clr_overflow = 1'b1;
    tick(1);
    bus.clr_overflow = 1'b0;
    chk("clr_alone", bus.overflow, 0);
    for (int i = 0; i < 4; i++) send(32'h40 + 32'(i), 1'b1);
    bus.rd_data     = 32'h44;
    bus.data_toggle = ~bus.data_toggle;
    tick(LAT - 1);
    bus.clr_overflow = 1'b1;
    tick(1);
    bus.clr_overflow = 1'b0;
    chk("set_wins",        bus.overflow, 1);
    chk("set_wins_count",  bus.rx_count, 14);
    bus.clr_overflow = 1'b1;
    tick(1);
    bus.clr_overflow = 1'b0;
    chk("clr_after_set", bus.overflow, 0);

    // Reset mid-operation at level 3
    bus.rready = 1'b1;
    tick(1);
    bus.rready = 1'b0;
    chk("pre_rst_level", bus.level, 3);
    bus.rd_data     = 32'h55;
    bus.data_toggle = 1'b0;
    Rst = 1'b0;
    expq.delete();
    #2;
    chk("mid_rst_rvalid",   bus.rvalid,   0);
    chk("mid_rst_level",    bus.level,    0);
    chk("mid_rst_rx_count", bus.rx_count, 0);
    chk("mid_rst_overflow", bus.overflow, 0);
    tick(1);
    Rst = 1'b1;
    tick(LAT + 2);
    chk("post_rst_level",  bus.level,    0);
    chk("post_rst_rvalid", bus.rvalid,   0);
    chk("post_rst_count",  bus.rx_count, 0);

    // Counter wrap with back-to-back toggles
    bus.rready  = 1'b1;
    bus.rd_data = 32'hCAFE_0000;
    for (int i = 0; i < 65537; i++) begin
      bus.data_toggle = ~bus.data_toggle;
      expq.push_back(32'hCAFE_0000);
      tick(1);
    end
    tick(LAT + 2);
    chk("wrap_rx_count", bus.rx_count, 1);
    chk("wrap_overflow", bus.overflow, 0);
    chk("wrap_level",    bus.level,    0);
    chk("sb_all_drained", 64'(expq.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
